// File: rtl/vga_timing_gen.sv
// VGA raster timing generator driven by an edge-detected pixel-clock level on the system clock.
// Optional macro VGA_TEST_PATTERN_EN adds a registered 12-bit colour-bar output (rgb).
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_clk,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             pix_stb,
  output logic             frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0]      rgb
`endif
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic             pix_clk_q;
  logic             tick;
  logic [CNT_W-1:0] x_nxt, y_nxt;
  logic [CNT_W-1:0] x_d, x_q, y_d, y_q;
  logic             de_d, de_q;
  logic             hsync_d, hsync_q;
  logic             vsync_d, vsync_q;
  logic             pix_stb_d, pix_stb_q;
  logic             frame_start_d, frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [11:0] rgb_d, rgb_q;

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [11:0] bar_rgb(input logic [CNT_W-1:0] col);
    logic [2:0] idx;
    logic [2:0] c;
    idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (32'(col) >= 32'(i) * BAR_W) idx = 3'(i);
    end
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction
`endif

  assign tick = pix_clk & ~pix_clk_q;

  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (x_q == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end else begin
      x_nxt = x_q + 1'b1;
    end
  end

  // Sync/enable are decoded from the next position so they stay aligned with x/y.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    de_d          = de_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    pix_stb_d     = 1'b0;
    frame_start_d = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    rgb_d         = rgb_q;
`endif
    if (tick) begin
      x_d           = x_nxt;
      y_d           = y_nxt;
      de_d          = (32'(x_nxt) < H_ACTIVE) && (32'(y_nxt) < V_ACTIVE);
      hsync_d       = ((32'(x_nxt) >= H_SYNC_BEG) && (32'(x_nxt) < H_SYNC_END)) ? H_POL : ~H_POL;
      vsync_d       = ((32'(y_nxt) >= V_SYNC_BEG) && (32'(y_nxt) < V_SYNC_END)) ? V_POL : ~V_POL;
      pix_stb_d     = 1'b1;
      frame_start_d = (x_nxt == '0) && (y_nxt == '0);
`ifdef VGA_TEST_PATTERN_EN
      rgb_d         = de_d ? bar_rgb(x_nxt) : 12'h000;
`endif
    end
  end

  // Reset parks on the last pixel so the first tick afterwards lands on (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_clk_q     <= 1'b0;
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      de_q          <= 1'b0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      pix_stb_q     <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      rgb_q         <= 12'h000;
`endif
    end else begin
      pix_clk_q     <= pix_clk;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pix_stb_q     <= pix_stb_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_TEST_PATTERN_EN
      rgb_q         <= rgb_d;
`endif
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pix_stb     = pix_stb_q;
  assign frame_start = frame_start_q;
`ifdef VGA_TEST_PATTERN_EN
  assign rgb         = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny, opposite-polarity instance
// share stimulus and are checked against a linear frame-position reference model.
module tb_vga_timing_gen;

  localparam int D_HA = 640, D_HFP = 16, D_HS = 96, D_HBP = 48;
  localparam int D_VA = 480, D_VFP = 10, D_VS = 2,  D_VBP = 33;
  localparam int D_HT = D_HA + D_HFP + D_HS + D_HBP;
  localparam int D_VT = D_VA + D_VFP + D_VS + D_VBP;

  localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
  localparam int S_VA = 12, S_VFP = 2, S_VS = 2, S_VBP = 3;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;

  logic clk = 1'b0;
  logic reset;
  logic pix_clk;

  logic       d_hsync, d_vsync, d_de, d_stb, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hsync, s_vsync, s_de, s_stb, s_fs;
  logic [4:0] s_x, s_y;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] d_rgb, s_rgb;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: position within the frame as one linear pixel index.
  int d_pos, s_pos;
  bit m_prev, m_stb;

  vga_timing_gen dut (
    .clk(clk), .reset(reset), .pix_clk(pix_clk),
    .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .x(d_x), .y(d_y),
    .pix_stb(d_stb), .frame_start(d_fs)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(d_rgb)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(5)
  ) dut_s (
    .clk(clk), .reset(reset), .pix_clk(pix_clk),
    .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .x(s_x), .y(s_y),
    .pix_stb(s_stb), .frame_start(s_fs)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(s_rgb)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] expRgb(input int col, input int ha, input bit vis);
    logic [2:0] c;
    if (!vis) return 12'h000;
    case (col / (ha / 8))
      0: c = 3'b111;
      1: c = 3'b110;
      2: c = 3'b011;
      3: c = 3'b010;
      4: c = 3'b101;
      5: c = 3'b100;
      6: c = 3'b001;
      default: c = 3'b000;
    endcase
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction

  task automatic checkDut(input string pfx, input int pos,
                          input int ha, input int hfp, input int hs, input int ht,
                          input int va, input int vfp, input int vs, input bit hpol, input bit vpol,
                          input logic [31:0] x_got, input logic [31:0] y_got,
                          input logic de_got, input logic hs_got, input logic vs_got,
                          input logic stb_got, input logic fs_got, input logic [11:0] rgb_got,
                          input bit chk_rgb);
    int ex, ey;
    bit ede, ehs, evs;
    ex  = pos % ht;
    ey  = pos / ht;
    ede = (ex < ha) && (ey < va);
    ehs = (ex >= ha + hfp && ex < ha + hfp + hs) ? hpol : !hpol;
    evs = (ey >= va + vfp && ey < va + vfp + vs) ? vpol : !vpol;
    checkOutput({pfx, ".x"}, x_got, 32'(ex));
    checkOutput({pfx, ".y"}, y_got, 32'(ey));
    checkOutput({pfx, ".de"}, 32'(de_got), 32'(ede));
    checkOutput({pfx, ".hsync"}, 32'(hs_got), 32'(ehs));
    checkOutput({pfx, ".vsync"}, 32'(vs_got), 32'(evs));
    checkOutput({pfx, ".pix_stb"}, 32'(stb_got), 32'(m_stb));
    checkOutput({pfx, ".frame_start"}, 32'(fs_got), 32'(m_stb && pos == 0));
    if (chk_rgb) checkOutput({pfx, ".rgb"}, 32'(rgb_got), 32'(expRgb(ex, ha, ede)));
  endtask

  // One clk cycle: drive inputs, advance the model at the edge, check #1 later.
  task automatic applyStimulus(input logic pc, input logic rst);
    bit tick;
    logic [11:0] d_rgb_v, s_rgb_v;
    bit has_rgb;
    pix_clk = pc;
    reset   = rst;
    @(posedge clk);
    if (rst) begin
      d_pos  = D_HT * D_VT - 1;
      s_pos  = S_HT * S_VT - 1;
      m_prev = 1'b0;
      m_stb  = 1'b0;
    end else begin
      tick   = pc && !m_prev;
      m_prev = pc;
      m_stb  = tick;
      if (tick) begin
        d_pos = (d_pos + 1) % (D_HT * D_VT);
        s_pos = (s_pos + 1) % (S_HT * S_VT);
      end
    end
    #1;
    has_rgb = 1'b0;
    d_rgb_v = 12'h000;
    s_rgb_v = 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    has_rgb = 1'b1;
    d_rgb_v = d_rgb;
    s_rgb_v = s_rgb;
`endif
    checkDut("d", d_pos, D_HA, D_HFP, D_HS, D_HT, D_VA, D_VFP, D_VS, 1'b0, 1'b0,
             32'(d_x), 32'(d_y), d_de, d_hsync, d_vsync, d_stb, d_fs, d_rgb_v, has_rgb);
    checkDut("s", s_pos, S_HA, S_HFP, S_HS, S_HT, S_VA, S_VFP, S_VS, 1'b1, 1'b1,
             32'(s_x), 32'(s_y), s_de, s_hsync, s_vsync, s_stb, s_fs, s_rgb_v, has_rgb);
  endtask

  task automatic runTicks(input int n, input int half);
    repeat (n) begin
      repeat (half) applyStimulus(1'b1, 1'b0);
      repeat (half) applyStimulus(1'b0, 1'b0);
    end
  endtask

  initial begin
    pix_clk = 1'b0;
    reset   = 1'b1;

    $display("[TB] reset held with pix_clk toggling");
    for (int i = 0; i < 5; i++) applyStimulus(1'(i % 2), 1'b1);

    $display("[TB] release reset, first tick enters (0,0)");
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] one full default line plus wrap, tick every 4 clks");
    runTicks(D_HT + 2, 2);

    $display("[TB] pix_clk held high mid-line");
    runTicks(150, 1);
    repeat (20) applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);

    $display("[TB] randomized pix_clk with occasional reset");
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 299) == 0));
    end

    $display("[TB] mid-frame reset, tick coincident with reset discarded");
    applyStimulus(1'b0, 1'b0);
    runTicks(300, 1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] several frames of the small instance");
    applyStimulus(1'b0, 1'b0);
    runTicks(S_HT * S_VT * 3 + 7, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
